rv32i_cpu_top: RTL and testbench

//  Top level of a small RV32I processor: core, 32x32 register file, instruction TCM (ITCM), data TCM (DTCM).

---
 rtl/rv32i_cpu_top.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_rv32i_cpu_top.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_cpu_top.sv
// Small multi-cycle RV32I processor with separate instruction and data TCMs.
// Each instruction takes FETCH then EXEC; loads add a MEM cycle for the synchronous DTCM read.
module rv32i_gnrl_ram #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_cs,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);
    logic [31:0] mem_r [0:DEPTH-1];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_cs) begin
            for (int k = 0; k < 4; k++)
                if (i_we[k]) mem_r[i_addr][8*k +: 8] <= i_wdata[8*k +: 8];
            r_rdata <= mem_r[i_addr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

module rv32i_itcm_ram #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_cs,
    input  logic [AW-1:0] i_addr,
    output logic [31:0]   o_rdata
);
    rv32i_gnrl_ram #(.DEPTH(DEPTH), .AW(AW)) u_itcm_gnrl_ram (
        .clk(clk), .i_cs(i_cs), .i_we(4'b0), .i_addr(i_addr),
        .i_wdata(32'b0), .o_rdata(o_rdata)
    );
endmodule

module rv32i_dtcm_ram #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_cs,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);
    rv32i_gnrl_ram #(.DEPTH(DEPTH), .AW(AW)) u_dtcm_gnrl_ram (
        .clk(clk), .i_cs(i_cs), .i_we(i_we), .i_addr(i_addr),
        .i_wdata(i_wdata), .o_rdata(o_rdata)
    );
endmodule

module rv32i_srams #(
    parameter int IDEPTH = 4096,
    parameter int DDEPTH = 4096,
    parameter int IAW    = $clog2(IDEPTH),
    parameter int DAW    = $clog2(DDEPTH)
) (
    input  logic           clk,
    input  logic           i_ics,
    input  logic [IAW-1:0] i_iaddr,
    output logic [31:0]    o_idata,
    input  logic           i_dcs,
    input  logic [3:0]     i_dwe,
    input  logic [DAW-1:0] i_daddr,
    input  logic [31:0]    i_dwdata,
    output logic [31:0]    o_ddata
);
    rv32i_itcm_ram #(.DEPTH(IDEPTH), .AW(IAW)) u_itcm_ram (
        .clk(clk), .i_cs(i_ics), .i_addr(i_iaddr), .o_rdata(o_idata)
    );
    rv32i_dtcm_ram #(.DEPTH(DDEPTH), .AW(DAW)) u_dtcm_ram (
        .clk(clk), .i_cs(i_dcs), .i_we(i_dwe), .i_addr(i_daddr),
        .i_wdata(i_dwdata), .o_rdata(o_ddata)
    );
endmodule

module rv32i_regfile (
    input  logic        clk,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata,
    input  logic [4:0]  i_raddr1,
    input  logic [4:0]  i_raddr2,
    output logic [31:0] o_rdata1,
    output logic [31:0] o_rdata2
);
    logic [31:0] rf_r [0:31];

    always_ff @(posedge clk) begin
        if (i_we && i_waddr != 5'd0) rf_r[i_waddr] <= i_wdata;
    end

    assign o_rdata1 = (i_raddr1 == 5'd0) ? 32'd0 : rf_r[i_raddr1];
    assign o_rdata2 = (i_raddr2 == 5'd0) ? 32'd0 : rf_r[i_raddr2];
endmodule

module rv32i_cpu_top #(
    parameter int PC_SIZE    = 32,
    parameter int ITCM_DEPTH = 4096,
    parameter int DTCM_DEPTH = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PC_SIZE-1:0] pc_rtvec
);
    localparam int IAW = $clog2(ITCM_DEPTH);
    localparam int DAW = $clog2(DTCM_DEPTH);

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM} state_t;

    state_t             r_state;
    logic [PC_SIZE-1:0] r_pc;
    logic               r_halted;

    logic [31:0] w_pc, w_instr, w_rs1, w_rs2, w_ddata, w_daddr;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [31:0] w_wb_data, w_next_pc, w_ld_data, w_st_data, w_rf_wdata;
    logic [31:0] w_byte, w_half;
    logic [6:0]  w_op;
    logic [4:0]  w_rd;
    logic [2:0]  w_f3;
    logic [3:0]  w_be, w_dtcm_we;
    logic        w_wb_en, w_is_load, w_is_store, w_halt, w_br_take;
    logic        w_live, w_rf_we, w_unused;

    assign w_pc    = 32'(r_pc);
    assign w_op    = w_instr[6:0];
    assign w_rd    = w_instr[11:7];
    assign w_f3    = w_instr[14:12];
    assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
    assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
    assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                      w_instr[30:25], w_instr[11:8], 1'b0};
    assign w_imm_u = {w_instr[31:12], 12'b0};
    assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                      w_instr[20], w_instr[30:21], 1'b0};

    function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] f, input logic alt);
        logic [31:0] r;
        case (f)
            3'd0:    r = alt ? a - b : a + b;
            3'd1:    r = a << b[4:0];
            3'd2:    r = {31'b0, $signed(a) < $signed(b)};
            3'd3:    r = {31'b0, a < b};
            3'd4:    r = a ^ b;
            3'd5:    r = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    always_comb begin
        case (w_f3)
            3'd0:    w_br_take = (w_rs1 == w_rs2);
            3'd1:    w_br_take = (w_rs1 != w_rs2);
            3'd4:    w_br_take = ($signed(w_rs1) < $signed(w_rs2));
            3'd5:    w_br_take = ($signed(w_rs1) >= $signed(w_rs2));
            3'd6:    w_br_take = (w_rs1 < w_rs2);
            3'd7:    w_br_take = (w_rs1 >= w_rs2);
            default: w_br_take = 1'b0;
        endcase
    end

    always_comb begin
        w_wb_en    = 1'b0;
        w_wb_data  = 32'd0;
        w_next_pc  = w_pc + 32'd4;
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_halt     = 1'b0;
        case (w_op)
            7'b0110111: begin w_wb_en = 1'b1; w_wb_data = w_imm_u; end
            7'b0010111: begin w_wb_en = 1'b1; w_wb_data = w_pc + w_imm_u; end
            7'b1101111: begin
                w_wb_en   = 1'b1;
                w_wb_data = w_pc + 32'd4;
                w_next_pc = w_pc + w_imm_j;
            end
            7'b1100111: begin
                w_wb_en   = 1'b1;
                w_wb_data = w_pc + 32'd4;
                w_next_pc = (w_rs1 + w_imm_i) & ~32'd1;
            end
            7'b1100011: if (w_br_take) w_next_pc = w_pc + w_imm_b;
            7'b0000011: w_is_load = 1'b1;
            7'b0100011: w_is_store = 1'b1;
            7'b0010011: begin
                w_wb_en   = 1'b1;
                w_wb_data = alu(w_rs1, w_imm_i, w_f3, w_instr[30] && w_f3 == 3'd5);
            end
            7'b0110011: begin
                w_wb_en   = 1'b1;
                w_wb_data = alu(w_rs1, w_rs2, w_f3, w_instr[30]);
            end
            // funct3=0 covers ECALL/EBREAK (halt) and MRET/WFI (no-op); CSR ops read as 0
            7'b1110011: begin
                if (w_f3 == 3'd0) w_halt = (w_instr[31:21] == 11'd0);
                else w_wb_en = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_daddr = w_rs1 + (w_is_store ? w_imm_s : w_imm_i);

    always_comb begin
        case (w_f3[1:0])
            2'd0: begin
                w_be      = 4'b0001 << w_daddr[1:0];
                w_st_data = {4{w_rs2[7:0]}};
            end
            2'd1: begin
                w_be      = w_daddr[1] ? 4'b1100 : 4'b0011;
                w_st_data = {2{w_rs2[15:0]}};
            end
            default: begin
                w_be      = 4'b1111;
                w_st_data = w_rs2;
            end
        endcase
    end

    assign w_byte = w_ddata >> {w_daddr[1:0], 3'b000};
    assign w_half = w_daddr[1] ? {16'd0, w_ddata[31:16]} : {16'd0, w_ddata[15:0]};

    always_comb begin
        case (w_f3)
            3'd0:    w_ld_data = {{24{w_byte[7]}}, w_byte[7:0]};
            3'd1:    w_ld_data = {{16{w_half[15]}}, w_half[15:0]};
            3'd4:    w_ld_data = {24'd0, w_byte[7:0]};
            3'd5:    w_ld_data = {16'd0, w_half[15:0]};
            default: w_ld_data = w_ddata;
        endcase
    end

    // Reset in the same cycle cancels any architectural write
    assign w_live     = !rst && !r_halted;
    assign w_rf_we    = w_live && w_rd != 5'd0 &&
                        ((r_state == S_EXEC && w_wb_en) || r_state == S_MEM);
    assign w_rf_wdata = (r_state == S_MEM) ? w_ld_data : w_wb_data;
    assign w_dtcm_we  = (w_live && r_state == S_EXEC && w_is_store) ? w_be : 4'b0;
    assign w_unused   = ^{w_daddr[31:DAW+2], w_pc[31:IAW+2], w_pc[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= pc_rtvec;
            r_state  <= S_FETCH;
            r_halted <= 1'b0;
        end else if (!r_halted) begin
            case (r_state)
                S_FETCH: r_state <= S_EXEC;
                S_EXEC: begin
                    if (w_halt) begin
                        r_halted <= 1'b1;
                        r_state  <= S_FETCH;
                    end else if (w_is_load) begin
                        r_state <= S_MEM;
                    end else begin
                        r_pc    <= PC_SIZE'(w_next_pc);
                        r_state <= S_FETCH;
                    end
                end
                S_MEM: begin
                    r_pc    <= r_pc + PC_SIZE'(4);
                    r_state <= S_FETCH;
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    rv32i_regfile u_regfile (
        .clk(clk), .i_we(w_rf_we), .i_waddr(w_rd), .i_wdata(w_rf_wdata),
        .i_raddr1(w_instr[19:15]), .i_raddr2(w_instr[24:20]),
        .o_rdata1(w_rs1), .o_rdata2(w_rs2)
    );

    rv32i_srams #(.IDEPTH(ITCM_DEPTH), .DDEPTH(DTCM_DEPTH)) u_srams (
        .clk(clk),
        .i_ics(r_state == S_FETCH), .i_iaddr(w_pc[IAW+1:2]), .o_idata(w_instr),
        .i_dcs(r_state == S_EXEC), .i_dwe(w_dtcm_we), .i_daddr(w_daddr[DAW+1:2]),
        .i_dwdata(w_st_data), .o_ddata(w_ddata)
    );
endmodule

// File: tb/tb_rv32i_cpu_top.sv
// Directed program bench for rv32i_cpu_top; a scoreboard pairs every
// register-file and DTCM write with the expected write queued by the stimulus.
module tb_rv32i_cpu_top;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_rtvec = 32'h80;

    always #5 clk = ~clk;

    rv32i_cpu_top dut (.clk(clk), .rst(rst), .pc_rtvec(pc_rtvec));

    typedef struct {
        bit          is_mem;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  failures = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_rf(input int rd, input logic [31:0] d);
        ev_t e;
        e.is_mem = 1'b0; e.addr = 32'(rd); e.data = d; e.be = 4'b0;
        exp_q.push_back(e);
    endtask

    task automatic exp_mem(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        ev_t e;
        e.is_mem = 1'b1; e.addr = a; e.data = d; e.be = be;
        exp_q.push_back(e);
    endtask

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                          input int rd, input logic [6:0] op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                          input int f3, input int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
    endfunction

    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] LD  = 7'b0000011;

    always @(negedge clk) begin
        ev_t e;
        if (dut.w_rf_we) begin
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_rf_write: got x%0d=%h required none",
                         dut.w_rd, dut.w_rf_wdata);
            end else begin
                e = exp_q.pop_front();
                check32("rf_write_kind", {31'b0, e.is_mem}, 32'd0);
                check32("rf_write_rd", {27'b0, dut.w_rd}, e.addr);
                check32("rf_write_data", dut.w_rf_wdata, e.data);
            end
        end
        if (dut.w_dtcm_we != 4'b0) begin
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_dtcm_write: got addr %h data %h required none",
                         dut.w_daddr, dut.w_st_data);
            end else begin
                e = exp_q.pop_front();
                check32("mem_write_kind", {31'b0, e.is_mem}, 32'd1);
                check32("mem_write_addr", dut.w_daddr, e.addr);
                check32("mem_write_data", dut.w_st_data, e.data);
                check32("mem_write_be", {28'b0, dut.w_dtcm_we}, {28'b0, e.be});
            end
        end
    end

    logic [31:0] prog [26];

    initial begin
        int n;
        int bad;
        prog[0]  = enc_i(5, 0, 0, 1, OPI);
        prog[1]  = enc_i(-7, 1, 0, 2, OPI);
        prog[2]  = {20'h12345, 5'd5, 7'b0110111};
        prog[3]  = enc_i(32'h678, 5, 0, 5, OPI);
        prog[4]  = enc_s(8, 5, 0, 2);
        prog[5]  = enc_i(9, 0, 4, 6, LD);
        prog[6]  = enc_i(11, 0, 0, 7, LD);
        prog[7]  = enc_i(0, 0, 0, 8, LD);
        prog[8]  = enc_i(0, 0, 5, 9, LD);
        prog[9]  = enc_b(8, 0, 0, 1);
        prog[10] = enc_b(8, 1, 2, 4);
        prog[11] = enc_i(32'h7FF, 0, 0, 10, OPI);
        prog[12] = enc_j(8, 11);
        prog[13] = enc_i(1, 0, 0, 10, OPI);
        prog[14] = enc_r(32'h20, 2, 1, 0, 12);
        prog[15] = enc_i(32'h401, 2, 5, 13, OPI);
        prog[16] = enc_r(0, 2, 1, 3, 14);
        prog[17] = enc_s(3, 1, 0, 0);
        prog[18] = enc_i(0, 0, 2, 16, LD);
        prog[19] = enc_i(32'hD5, 0, 0, 17, 7'b1100111);
        prog[20] = enc_i(2, 0, 0, 10, OPI);
        prog[21] = enc_i(32'h300, 0, 2, 18, 7'b1110011);
        prog[22] = 32'h0000000F;
        prog[23] = enc_i(1, 0, 0, 3, OPI);
        prog[24] = 32'h00000073;
        prog[25] = enc_i(9, 0, 0, 3, OPI);
        for (int i = 0; i < 26; i++)
            dut.u_srams.u_itcm_ram.u_itcm_gnrl_ram.mem_r[32 + i] = prog[i];
        dut.u_srams.u_dtcm_ram.u_dtcm_gnrl_ram.mem_r[0] = 32'hFFFFFF80;
        dut.u_srams.u_dtcm_ram.u_dtcm_gnrl_ram.mem_r[2] = 32'h0;

        exp_rf(1, 32'd5);
        exp_rf(2, 32'hFFFFFFFE);
        exp_rf(5, 32'h12345000);
        exp_rf(5, 32'h12345678);
        exp_mem(32'd8, 32'h12345678, 4'b1111);
        exp_rf(6, 32'h56);
        exp_rf(7, 32'h12);
        exp_rf(8, 32'hFFFFFF80);
        exp_rf(9, 32'h0000FF80);
        exp_rf(11, 32'hB4);
        exp_rf(12, 32'd7);
        exp_rf(13, 32'hFFFFFFFF);
        exp_rf(14, 32'd1);
        exp_mem(32'd3, 32'h05050505, 4'b1000);
        exp_rf(16, 32'h05FFFF80);
        exp_rf(17, 32'hD0);
        exp_rf(18, 32'd0);
        exp_rf(3, 32'd1);

        repeat (3) @(posedge clk);
        #1;
        check32("reset_pc", dut.r_pc, 32'h80);
        check32("reset_state", 32'(dut.r_state), 32'd0);
        check32("reset_halted", {31'b0, dut.r_halted}, 32'd0);
        rst = 1'b0;

        repeat (2) @(posedge clk);
        #1 check32("x1_after_2_cycles", dut.u_regfile.rf_r[1], 32'd5);
        repeat (2) @(posedge clk);
        #1 check32("x2_after_4_cycles", dut.u_regfile.rf_r[2], 32'hFFFFFFFE);

        n = 0;
        while (!dut.r_halted && n < 1000) begin
            @(posedge clk);
            #1 n++;
        end
        check32("halted_after_ecall", {31'b0, dut.r_halted}, 32'd1);
        check32("halt_pc", dut.r_pc, 32'hE0);

        bad = 0;
        repeat (100) begin
            @(posedge clk);
            #1 if (dut.r_pc !== 32'hE0) bad++;
        end
        check32("pc_frozen_cycles_bad", 32'(bad), 32'd0);
        check32("x3_after_halt", dut.u_regfile.rf_r[3], 32'd1);
        check32("x10_skipped", dut.u_regfile.rf_r[10] == 32'h7FF ||
                dut.u_regfile.rf_r[10] == 32'd1 || dut.u_regfile.rf_r[10] == 32'd2, 32'd0);
        check32("dtcm2_after_sw", dut.u_srams.u_dtcm_ram.u_dtcm_gnrl_ram.mem_r[2], 32'h12345678);
        check32("dtcm0_after_sb", dut.u_srams.u_dtcm_ram.u_dtcm_gnrl_ram.mem_r[0], 32'h05FFFF80);
        check32("pending_writes", 32'(exp_q.size()), 32'd0);

        rst = 1'b1;
        dut.u_srams.u_itcm_ram.u_itcm_gnrl_ram.mem_r[32] = enc_s(4, 1, 0, 2);
        dut.u_srams.u_dtcm_ram.u_dtcm_gnrl_ram.mem_r[1] = 32'hDEADBEEF;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 check32("store_in_exec", 32'(dut.r_state), 32'd1);
        pc_rtvec = 32'h200;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check32("abort_pc_rtvec", dut.r_pc, 32'h200);
        check32("abort_state", 32'(dut.r_state), 32'd0);
        check32("abort_dtcm1", dut.u_srams.u_dtcm_ram.u_dtcm_gnrl_ram.mem_r[1], 32'hDEADBEEF);
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
